// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and the
// MEM stage. MEM has fixed priority over IF. Each access holds bus_req until
// bus_ack or until the wait limit expires. A timeout sets the sticky bus_err.
// Pipeline stalls are derived from the registered completion pulses.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  // Last no-ack cycle before abort, and the saturation ceiling of the counter.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              cancel_q, cancel_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              mem_done_q, mem_done_d;

  logic              abort;
  logic              finish;
  logic              cancel_now;
  logic [DATA_W-1:0] fin_data;

  // An access ends on ack or when the wait limit expires; an aborted access returns zero.
  assign abort      = ~bus_ack & (wait_cnt_q == WAIT_LAST);
  assign finish     = bus_ack | abort;
  assign fin_data   = bus_ack ? bus_rdata : '0;
  assign cancel_now = cancel_q | flush;

  // Next-state and registered-output logic for the three-state access sequencer.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    cancel_d    = cancel_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_err_d   = bus_err_q;
    if_rdata_d  = if_rdata_q;
    if_valid_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;
    mem_done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A result being consumed this cycle blocks a new grant.
        if (!(mem_done_q || if_valid_q)) begin
          if (mem_read || mem_write) begin
            state_d     = MEM_WAIT;
            wait_cnt_d  = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write;
            bus_addr_d  = mem_addr;
            bus_wdata_d = mem_wdata;
          end else if (if_req) begin
            state_d    = IF_WAIT;
            wait_cnt_d = '0;
            cancel_d   = flush;
            bus_req_d  = 1'b1;
            bus_we_d   = 1'b0;
            bus_addr_d = if_addr;
          end
        end
      end
      IF_WAIT: begin
        if (flush) cancel_d = 1'b1;
        if (finish) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          if (abort) bus_err_d = 1'b1;
          if (!cancel_now) begin
            if_rdata_d = fin_data;
            if_valid_d = 1'b1;
          end
        end else if (wait_cnt_q != WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (finish) begin
          state_d     = IDLE;
          bus_req_d   = 1'b0;
          if (abort) bus_err_d = 1'b1;
          mem_rdata_d = fin_data;
          mem_done_d  = 1'b1;
        end else if (wait_cnt_q != WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears every output, including held data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      cancel_q    <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      mem_rdata_q <= '0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      cancel_q    <= cancel_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_err_q   <= bus_err_d;
      if_rdata_q  <= if_rdata_d;
      if_valid_q  <= if_valid_d;
      mem_rdata_q <= mem_rdata_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_err   = bus_err_q;
  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_done  = mem_done_q;

  // A cancelled fetch keeps IF stalled until the discarded access drains.
  assign stall_mem = (mem_read | mem_write) & ~mem_done_q;
  assign stall_if  = (if_req & ~if_valid_q) | stall_mem |
                     ((state_q == IF_WAIT) & cancel_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized
// transactions checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int MAXW = 15;

  logic        clk = 1'b0;
  logic        rst, if_req, flush, mem_read, mem_write, bus_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic        if_valid, mem_done, stall_if, stall_mem, bus_req, bus_we, bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          got_req;
    int          idle;
    int          req_cycles;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    bit          stable;
    bit          smem_held;
    bit          sif_held;
    logic        done;
    logic        valid;
    logic [31:0] mrd;
    logic [31:0] ird;
    logic        err;
  } obs_t;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Plays the memory side of one access: waits for bus_req, acks on the
  // ack_after-th request cycle (never if beyond the wait limit), optionally
  // pulses flush on request cycle flush_at (which also redirects the PC by
  // +0x40), and reports what was seen up to the cycle bus_req fell.
  task automatic do_access(input int ack_after, input logic [31:0] rdata,
                           input int flush_at, output obs_t o);
    int cnt;
    o = '{default: 0};
    o.stable = 1; o.smem_held = 1; o.sif_held = 1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (bus_req) begin
        o.got_req = 1;
        break;
      end
      o.idle++;
      o.sif_held &= stall_if;
    end
    if (!o.got_req) return;
    o.addr = bus_addr; o.we = bus_we; o.wdata = bus_wdata;
    for (int i = 0; i < 40; i++) begin
      if (!bus_req) break;
      cnt++;
      if (bus_addr !== o.addr || bus_we !== o.we || bus_wdata !== o.wdata) o.stable = 0;
      o.smem_held &= stall_mem;
      o.sif_held  &= stall_if;
      if (cnt == flush_at) begin
        flush = 1'b1;
        if_addr = if_addr + 32'h40;
      end
      if (cnt == ack_after) begin
        bus_ack = 1'b1; bus_rdata = rdata;
      end else begin
        bus_rdata = $urandom;
      end
      @(negedge clk);
      bus_ack = 1'b0;
      flush = 1'b0;
    end
    o.req_cycles = cnt;
    o.done = mem_done; o.valid = if_valid;
    o.mrd = mem_rdata; o.ird = if_rdata; o.err = bus_err;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 0; flush = 0; mem_read = 0; mem_write = 0; bus_ack = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus_req, bus_we, if_valid, mem_done, stall_if, stall_mem, bus_err} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000000",
        {bus_req, bus_we, if_valid, mem_done, stall_if, stall_mem, bus_err});
    end
    n_checks++;
    if ({bus_addr, bus_wdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_bus: got %h expected 0", {bus_addr, bus_wdata});
    end
    n_checks++;
    if ({if_rdata, mem_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 0", {if_rdata, mem_rdata});
    end
    rst = 1'b0;
  endtask

  task automatic test_load();
    obs_t o;
    mem_read = 1'b1; mem_addr = 32'h100;
    #1;
    n_checks++;
    if (stall_mem !== 1'b1) begin n_fail++; $display("FAIL load_stall_start: got %b expected 1", stall_mem); end
    do_access(3, 32'hDEADBEEF, 0, o);
    n_checks++;
    if (!o.got_req || o.idle != 0) begin
      n_fail++; $display("FAIL load_grant: got req=%0d idle=%0d expected req=1 idle=0", o.got_req, o.idle);
    end
    n_checks++;
    if (o.req_cycles != 3) begin n_fail++; $display("FAIL load_req_cycles: got %0d expected 3", o.req_cycles); end
    n_checks++;
    if (o.addr !== 32'h100 || o.we !== 1'b0 || !o.stable) begin
      n_fail++; $display("FAIL load_bus: got addr=%h we=%b stable=%0d expected addr=100 we=0 stable=1", o.addr, o.we, o.stable);
    end
    n_checks++;
    if (!o.smem_held) begin n_fail++; $display("FAIL load_stall_held: got 0 expected 1"); end
    n_checks++;
    if (o.done !== 1'b1 || o.mrd !== 32'hDEADBEEF || o.valid !== 1'b0) begin
      n_fail++; $display("FAIL load_done: got done=%b rdata=%h valid=%b expected 1 deadbeef 0", o.done, o.mrd, o.valid);
    end
    n_checks++;
    if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL load_stall_release: got %b expected 0", stall_mem); end
    mem_read = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_done !== 1'b0 || mem_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL load_pulse_hold: got done=%b rdata=%h expected 0 deadbeef", mem_done, mem_rdata);
    end
  endtask

  task automatic test_store();
    obs_t o;
    mem_write = 1'b1; mem_addr = 32'h20; mem_wdata = 32'h1234;
    do_access(1, 32'h0, 0, o);
    n_checks++;
    if (o.addr !== 32'h20 || o.we !== 1'b1 || o.wdata !== 32'h1234) begin
      n_fail++; $display("FAIL store_bus: got addr=%h we=%b wdata=%h expected 20 1 1234", o.addr, o.we, o.wdata);
    end
    n_checks++;
    if (o.req_cycles != 1 || o.done !== 1'b1) begin
      n_fail++; $display("FAIL store_done: got cycles=%0d done=%b expected 1 1", o.req_cycles, o.done);
    end
    mem_write = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_done !== 1'b0) begin n_fail++; $display("FAIL store_pulse: got %b expected 0", mem_done); end
  endtask

  task automatic test_priority();
    obs_t o1, o2;
    if_req = 1'b1; if_addr = 32'h40; mem_read = 1'b1; mem_addr = 32'h200;
    do_access(2, 32'hA5A50001, 0, o1);
    n_checks++;
    if (o1.addr !== 32'h200 || o1.done !== 1'b1 || o1.valid !== 1'b0) begin
      n_fail++; $display("FAIL prio_mem_first: got addr=%h done=%b valid=%b expected 200 1 0", o1.addr, o1.done, o1.valid);
    end
    n_checks++;
    if (!o1.sif_held) begin n_fail++; $display("FAIL prio_stall_if_mem: got 0 expected 1"); end
    mem_read = 1'b0;
    do_access(2, 32'h00C0FFEE, 0, o2);
    n_checks++;
    if (o2.idle != 1 || o2.addr !== 32'h40 || o2.we !== 1'b0) begin
      n_fail++; $display("FAIL prio_if_grant: got idle=%0d addr=%h we=%b expected 1 40 0", o2.idle, o2.addr, o2.we);
    end
    n_checks++;
    if (!o2.sif_held || o2.valid !== 1'b1 || o2.ird !== 32'h00C0FFEE) begin
      n_fail++; $display("FAIL prio_if_done: got held=%0d valid=%b rdata=%h expected 1 1 00c0ffee", o2.sif_held, o2.valid, o2.ird);
    end
    if_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b0) begin n_fail++; $display("FAIL prio_valid_pulse: got %b expected 0", if_valid); end
  endtask

  task automatic test_flush();
    obs_t o1, o2;
    if_req = 1'b1; if_addr = 32'h44;
    do_access(3, 32'h13, 1, o1);
    n_checks++;
    if (o1.addr !== 32'h44 || !o1.stable || !o1.sif_held) begin
      n_fail++; $display("FAIL flush_bus: got addr=%h stable=%0d stall=%0d expected 44 1 1", o1.addr, o1.stable, o1.sif_held);
    end
    n_checks++;
    if (o1.valid !== 1'b0 || o1.ird !== 32'h00C0FFEE) begin
      n_fail++; $display("FAIL flush_discard: got valid=%b rdata=%h expected 0 00c0ffee", o1.valid, o1.ird);
    end
    do_access(2, 32'h0BADF00D, 0, o2);
    n_checks++;
    if (o2.addr !== 32'h84 || o2.valid !== 1'b1 || o2.ird !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL flush_refetch: got addr=%h valid=%b rdata=%h expected 84 1 0badf00d", o2.addr, o2.valid, o2.ird);
    end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    obs_t o1, o2;
    mem_read = 1'b1; mem_addr = 32'h300;
    do_access(99, 32'h0, 0, o1);
    n_checks++;
    if (o1.req_cycles != MAXW) begin n_fail++; $display("FAIL timeout_cycles: got %0d expected %0d", o1.req_cycles, MAXW); end
    n_checks++;
    if (o1.done !== 1'b1 || o1.mrd !== 32'h0 || o1.err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_done: got done=%b rdata=%h err=%b expected 1 0 1", o1.done, o1.mrd, o1.err);
    end
    mem_read = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky_idle: got %b expected 1", bus_err); end
    mem_read = 1'b1; mem_addr = 32'h304;
    do_access(2, 32'h55AA55AA, 0, o2);
    n_checks++;
    if (o2.err !== 1'b1 || o2.mrd !== 32'h55AA55AA) begin
      n_fail++; $display("FAIL timeout_sticky_access: got err=%b rdata=%h expected 1 55aa55aa", o2.err, o2.mrd);
    end
    mem_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    mem_read = 1'b1; mem_addr = 32'h400;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_wait: got %b expected 1", bus_req); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_read = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    n_checks++;
    if ({bus_req, mem_done, bus_err} !== 3'b0 || mem_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_clear: got req/done/err=%b rdata=%h expected 000 0", {bus_req, mem_done, bus_err}, mem_rdata);
    end
    @(negedge clk);
    bus_ack = 1'b0;
    n_checks++;
    if ({bus_req, mem_done, stall_mem} !== 3'b0 || mem_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_late_ack: got req/done/stall=%b rdata=%h expected 000 0", {bus_req, mem_done, stall_mem}, mem_rdata);
    end
  endtask

  // Reference model: each access lasts min(ack delay, MAXW) request cycles;
  // beyond MAXW it times out returning zero and latching the error. MEM
  // accesses always complete; fetches complete unless flushed.
  task automatic test_random();
    obs_t o;
    int kind, ack, fl, exp_cycles;
    bit to, is_mem, exp_we, exp_err;
    logic [31:0] addr, wdata, rd, exp_data, last_mrd, last_ird;
    exp_err = 0; last_mrd = mem_rdata; last_ird = if_rdata;
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 3));
      ack = int'($urandom_range(1, MAXW + 2));
      addr = $urandom; wdata = $urandom; rd = $urandom;
      fl = 0;
      if (kind == 3 && ack >= 2 && ack <= MAXW && $urandom_range(0, 2) == 0)
        fl = int'($urandom_range(1, ack - 1));
      is_mem = (kind != 3);
      exp_we = (kind == 1 || kind == 2);
      mem_read  = (kind == 0 || kind == 2);
      mem_write = exp_we;
      mem_addr = addr; mem_wdata = wdata;
      if_req = !is_mem; if_addr = addr;
      do_access(ack, rd, fl, o);
      to = (ack > MAXW);
      exp_cycles = to ? MAXW : ack;
      exp_data = to ? 32'h0 : rd;
      exp_err |= to;
      if (is_mem) last_mrd = exp_data;
      else if (fl == 0) last_ird = exp_data;
      n_checks++;
      if (!o.got_req || o.idle != 0 || o.req_cycles != exp_cycles) begin
        n_fail++; $display("FAIL rand_timing[%0d]: got req=%0d idle=%0d cycles=%0d expected 1 0 %0d", t, o.got_req, o.idle, o.req_cycles, exp_cycles);
      end
      n_checks++;
      if (o.addr !== addr || o.we !== exp_we || !o.stable || (exp_we && o.wdata !== wdata)) begin
        n_fail++; $display("FAIL rand_bus[%0d]: got addr=%h we=%b wdata=%h stable=%0d expected %h %b %h 1", t, o.addr, o.we, o.wdata, o.stable, addr, exp_we, wdata);
      end
      n_checks++;
      if (o.done !== is_mem || o.valid !== (!is_mem && fl == 0)) begin
        n_fail++; $display("FAIL rand_pulse[%0d]: got done=%b valid=%b expected %b %b", t, o.done, o.valid, is_mem, (!is_mem && fl == 0));
      end
      n_checks++;
      if (o.mrd !== last_mrd || o.ird !== last_ird) begin
        n_fail++; $display("FAIL rand_rdata[%0d]: got mem=%h if=%h expected %h %h", t, o.mrd, o.ird, last_mrd, last_ird);
      end
      n_checks++;
      if (o.err !== exp_err) begin n_fail++; $display("FAIL rand_err[%0d]: got %b expected %b", t, o.err, exp_err); end
      mem_read = 1'b0; mem_write = 1'b0; if_req = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_priority();
    test_flush();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
